// File: rtl/fnd_pkg.sv
// Shared constants and decode helpers for the FND digit-select path.
// Widths are carried in a 16-bit vector, the largest supported DIGITS.
package fnd_pkg;

  localparam int FND_DIGITS_DEFAULT = 4;
  localparam int FND_SEL_W_DEFAULT  = 2;
  localparam int FND_MAX_DIGITS     = 16;

  typedef logic [FND_MAX_DIGITS-1:0] fnd_vec_t;

  // All digits dark; bits above width stay 0.
  function automatic fnd_vec_t fnd_off(
    input bit active_low,
    input int width
  );
    fnd_vec_t v;
    v = '0;
    for (int i = 0; i < FND_MAX_DIGITS; i++) begin
      if (i < width) v[i] = active_low;
    end
    return v;
  endfunction

  // Single lit digit at sel; out-of-range sel stays dark.
  function automatic fnd_vec_t fnd_onehot(
    input int sel,
    input int width,
    input bit active_low
  );
    fnd_vec_t v;
    v = fnd_off(active_low, width);
    for (int i = 0; i < FND_MAX_DIGITS; i++) begin
      if (i < width && i == sel) v[i] = ~active_low;
    end
    return v;
  endfunction

endpackage

// File: rtl/fnd_onehot_dec.sv
// Combinational digit index to one-hot decoder.
// Indices at or beyond DIGITS decode to the dark pattern.
module fnd_onehot_dec
  import fnd_pkg::*;
#(
  parameter int DIGITS     = FND_DIGITS_DEFAULT,
  parameter int SEL_W      = FND_SEL_W_DEFAULT,
  parameter int ACTIVE_LOW = 1
) (
  input  logic [SEL_W-1:0]  i_sel,
  output logic [DIGITS-1:0] o_onehot
);

  fnd_vec_t dec;

  // Range-checked decode, trimmed to the digit count.
  always_comb begin
    dec = fnd_onehot(int'(i_sel), DIGITS, ACTIVE_LOW != 0);
    o_onehot = dec[DIGITS-1:0];
  end

endmodule

// File: rtl/fnd_select_decoder.sv
// Registered anode-select decoder for the multiplexed FND display.
// FND_GHOST_BLANK_EN adds one dark cycle whenever the lit digit changes.
module fnd_select_decoder
  import fnd_pkg::*;
#(
  parameter int DIGITS     = FND_DIGITS_DEFAULT,
  parameter int SEL_W      = FND_SEL_W_DEFAULT,
  parameter int ACTIVE_LOW = 1
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic [SEL_W-1:0]  i_digitSelect,
  input  logic              i_en,
  output logic [DIGITS-1:0] o_digit
);

  localparam fnd_vec_t OFF_FULL =
    fnd_off(ACTIVE_LOW != 0, DIGITS);
  localparam logic [DIGITS-1:0] OFF =
    OFF_FULL[DIGITS-1:0];

  logic [DIGITS-1:0] dec;
  logic [DIGITS-1:0] digit_d;
  logic [DIGITS-1:0] digit_q;

  fnd_onehot_dec #(
    .DIGITS    (DIGITS),
    .SEL_W     (SEL_W),
    .ACTIVE_LOW(ACTIVE_LOW)
  ) u_dec (
    .i_sel   (i_digitSelect),
    .o_onehot(dec)
  );

`ifdef FND_GHOST_BLANK_EN
  logic [SEL_W-1:0] held_sel_d;
  logic [SEL_W-1:0] held_sel_q;
  logic             held_vld_d;
  logic             held_vld_q;

  // Dark for one cycle on any new or freshly enabled digit.
  always_comb begin
    digit_d    = OFF;
    held_sel_d = held_sel_q;
    held_vld_d = held_vld_q;
    if (!i_en) begin
      held_vld_d = 1'b0;
    end else if (!held_vld_q ||
                 held_sel_q != i_digitSelect) begin
      held_sel_d = i_digitSelect;
      held_vld_d = 1'b1;
    end else begin
      digit_d = dec;
    end
  end

  // Held index; reset makes it invalid.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      held_sel_q <= '0;
      held_vld_q <= 1'b0;
    end else begin
      held_sel_q <= held_sel_d;
      held_vld_q <= held_vld_d;
    end
  end
`else
  // Enable gates the decode; disabled means dark.
  always_comb begin
    digit_d = OFF;
    if (i_en) digit_d = dec;
  end
`endif

  // Output register; reset forces all digits dark.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) digit_q <= OFF;
    else            digit_q <= digit_d;
  end

  assign o_digit = digit_q;

endmodule

// File: tb/tb_fnd_select_decoder.sv
// Bench for fnd_select_decoder: default, 3-digit and active-high builds.
// Expected values come from an index-based model of the display.
module tb_fnd_select_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [1:0] sel = 2'd0;
  logic [3:0] dig4;
  logic [2:0] dig3;
  logic [3:0] dig_ah;

  int n_cmp = 0;
  int n_bad = 0;
  int last_idx = -1;

  always #5 clk = ~clk;

  fnd_select_decoder #(
    .DIGITS(4), .SEL_W(2), .ACTIVE_LOW(1)
  ) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_digitSelect(sel), .i_en(en),
    .o_digit(dig4)
  );

  fnd_select_decoder #(
    .DIGITS(3), .SEL_W(2), .ACTIVE_LOW(1)
  ) dut3 (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_digitSelect(sel), .i_en(en),
    .o_digit(dig3)
  );

  fnd_select_decoder #(
    .DIGITS(4), .SEL_W(2), .ACTIVE_LOW(0)
  ) dut_ah (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_digitSelect(sel), .i_en(en),
    .o_digit(dig_ah)
  );

  // Pattern for "digit idx lit" (idx < 0 means none lit).
  function automatic logic [15:0] pat(
    input int n, input bit al, input int idx
  );
    int v;
    int mask;
    mask = (1 << n) - 1;
    v = (idx >= 0 && idx < n) ? (1 << idx) : 0;
    if (al) v = ~v & mask;
    return 16'(v);
  endfunction

  task automatic chk(
    input string tag,
    input logic [15:0] obs,
    input logic [15:0] exp
  );
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Apply inputs for one edge, then check all builds.
  task automatic step(
    input string tag,
    input bit r, input bit e, input int s
  );
    int idx;
    rst_n = r;
    en = e;
    sel = 2'(s);
    @(posedge clk);
    #1;
    idx = -1;
    if (!r) begin
      last_idx = -1;
    end else if (!e) begin
      last_idx = -1;
    end else begin
`ifdef FND_GHOST_BLANK_EN
      if (s == last_idx) idx = s;
      last_idx = s;
`else
      idx = s;
`endif
    end
    chk({tag, "/d4"}, 16'(dig4), pat(4, 1'b1, idx));
    chk({tag, "/d3"}, 16'(dig3), pat(3, 1'b1, idx));
    chk({tag, "/ah"}, 16'(dig_ah), pat(4, 1'b0, idx));
  endtask

  initial begin
    step("rst0", 1'b0, 1'b1, 2);
    step("rst1", 1'b0, 1'b1, 2);
    step("rel", 1'b1, 1'b1, 2);
    step("rel_hold", 1'b1, 1'b1, 2);
    for (int i = 0; i < 4; i++) begin
      step("en_sweep", 1'b1, 1'b1, i);
      step("en_hold", 1'b1, 1'b1, i);
    end
    for (int i = 0; i < 4; i++) begin
      step("dis_sweep", 1'b1, 1'b0, i);
    end
    step("pre_sim", 1'b1, 1'b1, 3);
    step("pre_sim2", 1'b1, 1'b1, 3);
    step("sim_chg", 1'b1, 1'b0, 0);
    step("reen", 1'b1, 1'b1, 1);
    step("reen2", 1'b1, 1'b1, 1);
    step("oor", 1'b1, 1'b1, 3);
    step("oor2", 1'b1, 1'b1, 3);
    step("in_rng", 1'b1, 1'b1, 2);
    step("in_rng2", 1'b1, 1'b1, 2);
    step("ah01", 1'b1, 1'b1, 1);
    step("ah01b", 1'b1, 1'b1, 1);
    step("mid_rst", 1'b0, 1'b1, 1);
    step("post_rst", 1'b1, 1'b1, 1);
    step("post_rst2", 1'b1, 1'b1, 1);
    for (int i = 0; i < 300; i++) begin
      step("rand",
           ($urandom_range(0, 19) != 0),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 2) == 0)
             ? int'(sel)
             : int'($urandom_range(0, 3)));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
